// File: rtl/tft_seqmod.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tft_seqmod                                                       |
// | Desc    : TFT call sequencer: power-up wait, init/clear/draw calls, then   |
// |           periodic clear/draw refresh. Optional watchdog via macro         |
// |           TFT_SEQ_TIMEOUT_EN.                                              |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tft_seqmod #(
    parameter int T_PWRUP   = 5_000_000,
    parameter int T_GAP     = 2,
    parameter int T_HOLD    = 25_000_000,
    parameter int T_TIMEOUT = 10_000_000
) (
    input  logic       CLOCK,
    input  logic       RESET,
    output logic [2:0] oCall,
    input  logic       iDone,
    input  logic       iPause,
    input  logic       iRestart,
    output logic       oBusy,
    output logic [7:0] oFrameCnt,
    output logic       oError
);

    localparam logic [2:0] S_PWRUP = 3'd0;
    localparam logic [2:0] S_INIT  = 3'd1;
    localparam logic [2:0] S_CLEAR = 3'd2;
    localparam logic [2:0] S_DRAW  = 3'd3;
    localparam logic [2:0] S_GAP   = 3'd4;
    localparam logic [2:0] S_HOLD  = 3'd5;
    localparam logic [2:0] S_ERROR = 3'd6;

    localparam logic [31:0] c_pwrup_last = 32'(T_PWRUP - 1);
    localparam logic [31:0] c_gap_last   = 32'(T_GAP - 1);
    localparam logic [31:0] c_hold_last  = 32'(T_HOLD - 1);

    logic [2:0]  r_state;
    logic [2:0]  r_next_state;
    logic [31:0] r_cnt;
    logic [2:0]  r_call;
    logic        r_busy;
    logic [7:0]  r_frame;

    logic [2:0]  w_state_nxt;
    logic [2:0]  w_next_nxt;
    logic [31:0] w_cnt_nxt;
    logic [2:0]  w_call_nxt;
    logic        w_frame_inc;
    logic        w_restart;
    logic        w_timeout;

    assign w_restart = iRestart && (r_state != S_PWRUP);

`ifdef TFT_SEQ_TIMEOUT_EN
    localparam logic [31:0] c_timeout_last = 32'(T_TIMEOUT - 1);

    // r_cnt doubles as the watchdog: it is zeroed on every entry into a call state.
    assign w_timeout = (r_state == S_INIT || r_state == S_CLEAR || r_state == S_DRAW)
                       && !iDone && (r_cnt == c_timeout_last);
`else
    logic w_unused_cfg;
    assign w_unused_cfg = (T_TIMEOUT > 0);
    assign w_timeout    = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_next_nxt  = r_next_state;
        w_cnt_nxt   = r_cnt;
        w_frame_inc = 1'b0;
        case (r_state)
            S_PWRUP: begin
                if (r_cnt == c_pwrup_last) begin
                    w_state_nxt = S_INIT;
                    w_cnt_nxt   = 32'd0;
                end else begin
                    w_cnt_nxt = r_cnt + 32'd1;
                end
            end
            S_INIT, S_CLEAR, S_DRAW: begin
                if (iDone) begin
                    w_state_nxt = S_GAP;
                    w_cnt_nxt   = 32'd0;
                    w_frame_inc = (r_state == S_DRAW);
                    case (r_state)
                        S_INIT:  w_next_nxt = S_CLEAR;
                        S_CLEAR: w_next_nxt = S_DRAW;
                        default: w_next_nxt = S_HOLD;
                    endcase
                end else if (w_timeout) begin
                    w_state_nxt = S_ERROR;
                    w_cnt_nxt   = 32'd0;
                end else begin
                    w_cnt_nxt = r_cnt + 32'd1;
                end
            end
            S_GAP: begin
                if (r_cnt == c_gap_last) begin
                    w_state_nxt = r_next_state;
                    w_cnt_nxt   = 32'd0;
                end else begin
                    w_cnt_nxt = r_cnt + 32'd1;
                end
            end
            S_HOLD: begin
                // Counter saturates at expiry while paused.
                if (r_cnt == c_hold_last) begin
                    if (!iPause) begin
                        w_state_nxt = S_GAP;
                        w_next_nxt  = S_CLEAR;
                        w_cnt_nxt   = 32'd0;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 32'd1;
                end
            end
            default: begin
                w_state_nxt = r_state;
            end
        endcase
        // Restart overrides everything, but a coincident draw completion still counts.
        if (w_restart) begin
            w_state_nxt = S_GAP;
            w_next_nxt  = S_INIT;
            w_cnt_nxt   = 32'd0;
        end
    end

    always_comb begin
        case (w_state_nxt)
            S_INIT:  w_call_nxt = 3'b100;
            S_CLEAR: w_call_nxt = 3'b010;
            S_DRAW:  w_call_nxt = 3'b001;
            default: w_call_nxt = 3'b000;
        endcase
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            r_state      <= S_PWRUP;
            r_next_state <= S_INIT;
            r_cnt        <= 32'd0;
            r_call       <= 3'b000;
            r_busy       <= 1'b0;
            r_frame      <= 8'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_next_state <= w_next_nxt;
            r_cnt        <= w_cnt_nxt;
            r_call       <= w_call_nxt;
            r_busy       <= |w_call_nxt;
            if (w_frame_inc) begin
                r_frame <= r_frame + 8'd1;
            end
        end
    end

`ifdef TFT_SEQ_TIMEOUT_EN
    logic r_err;

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            r_err <= 1'b0;
        end else if (w_restart) begin
            r_err <= 1'b0;
        end else if (w_timeout) begin
            r_err <= 1'b1;
        end
    end

    assign oError = r_err;
`else
    assign oError = 1'b0;
`endif

    assign oCall     = r_call;
    assign oBusy     = r_busy;
    assign oFrameCnt = r_frame;

endmodule
`default_nettype wire
